// File: rtl/decode_compressed_if.sv
// decode_compressed_if
//   Bundles the compressed-decoder datapath: the 16-bit candidate instruction
//   going in and the registered expansion coming out.
//   Signals:
//     com_inst_i      16  candidate compressed instruction
//     com_inst_o       8  expanded instruction code
//     com_reg_dr_o     5  destination register index
//     com_reg_sr1_o    5  source register 1 index
//     com_reg_sr2_o    5  source register 2 index
//     com_imm_data_o  32  expanded immediate
//     com_inst_val_o   1  registered outputs hold a valid RV32C instruction
//   Modports:
//     master  drives the instruction and receives the expansion (decode stage)
//     slave   the decoder itself
interface decode_compressed_if;
  logic [15:0] com_inst_i;
  logic [7:0]  com_inst_o;
  logic [4:0]  com_reg_dr_o;
  logic [4:0]  com_reg_sr1_o;
  logic [4:0]  com_reg_sr2_o;
  logic [31:0] com_imm_data_o;
  logic        com_inst_val_o;

  modport master (
    output com_inst_i,
    input  com_inst_o, com_reg_dr_o, com_reg_sr1_o, com_reg_sr2_o,
    input  com_imm_data_o, com_inst_val_o
  );

  modport slave (
    input  com_inst_i,
    output com_inst_o, com_reg_dr_o, com_reg_sr1_o, com_reg_sr2_o,
    output com_imm_data_o, com_inst_val_o
  );
endinterface

// File: rtl/decode_compressed.sv
// decode_compressed
//   RV32C expander for the rv32imac decode stage. Every rising clock edge
//   registers the base-ISA equivalent (instruction code, register indices,
//   final 32-bit immediate) of the 16-bit instruction on bus.com_inst_i.
//   Illegal or non-compressed encodings register the ILLEGAL code with all
//   register/immediate fields zero and com_inst_val_o low.
//   Ports:
//     clk_i  clock, all state on the rising edge
//     rst_i  asynchronous active-high reset, clears every output
//     bus    decode_compressed_if.slave (instruction in, expansion out)

// Instruction codes shared with the 32-bit decode path.
`ifndef ADDI
`define LUI     8'd1
`define JAL     8'd3
`define JALR    8'd4
`define BEQ     8'd5
`define BNE     8'd6
`define LW      8'd13
`define SW      8'd18
`define ADDI    8'd19
`define ANDI    8'd25
`define SLLI    8'd26
`define SRLI    8'd27
`define SRAI    8'd28
`define ADD     8'd29
`define SUB     8'd30
`define XOR     8'd33
`define OR      8'd36
`define AND     8'd37
`define ILLEGAL 8'd63
`endif

module decode_compressed (
  input  logic               clk_i,
  input  logic               rst_i,
  decode_compressed_if.slave bus
);

  logic [15:0] c;
  logic [4:0]  rd, rs2, rd_p, rs1_p;
  logic [31:0] imm6_s, jimm, bimm;

  logic [7:0]  inst_next;
  logic [4:0]  dr_next, sr1_next, sr2_next;
  logic [31:0] imm_next;
  logic        legal;

  assign c     = bus.com_inst_i;
  assign rd    = c[11:7];
  assign rs2   = c[6:2];
  // Compressed 3-bit register fields address x8..x15.
  assign rd_p  = {2'b01, c[4:2]};
  assign rs1_p = {2'b01, c[9:7]};

  assign imm6_s = {{26{c[12]}}, c[12], c[6:2]};
  assign jimm   = {{20{c[12]}}, c[12], c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3], 1'b0};
  assign bimm   = {{23{c[12]}}, c[12], c[6:5], c[2], c[11:10], c[4:3], 1'b0};

  always_comb begin
    inst_next = `ILLEGAL;
    dr_next   = 5'd0;
    sr1_next  = 5'd0;
    sr2_next  = 5'd0;
    imm_next  = 32'd0;
    legal     = 1'b0;
    case ({c[1:0], c[15:13]})
      // ---------------- quadrant 0 ----------------
      5'b00_000: begin  // ADDI4SPN; zero immediate also catches 16'h0000
        inst_next = `ADDI; dr_next = rd_p; sr1_next = 5'd2;
        imm_next  = {22'd0, c[10:7], c[12:11], c[5], c[6], 2'b00};
        legal     = (c[12:5] != 8'd0);
      end
      5'b00_010: begin
        inst_next = `LW; dr_next = rd_p; sr1_next = rs1_p;
        imm_next  = {25'd0, c[5], c[12:10], c[6], 2'b00};
        legal     = 1'b1;
      end
      5'b00_110: begin
        inst_next = `SW; sr1_next = rs1_p; sr2_next = rd_p;
        imm_next  = {25'd0, c[5], c[12:10], c[6], 2'b00};
        legal     = 1'b1;
      end
      // ---------------- quadrant 1 ----------------
      5'b01_000: begin  // ADDI / NOP
        inst_next = `ADDI; dr_next = rd; sr1_next = rd; imm_next = imm6_s; legal = 1'b1;
      end
      5'b01_001, 5'b01_101: begin  // JAL links to ra, J discards the link
        inst_next = `JAL; dr_next = c[15] ? 5'd0 : 5'd1; imm_next = jimm; legal = 1'b1;
      end
      5'b01_010: begin  // LI
        inst_next = `ADDI; dr_next = rd; imm_next = imm6_s; legal = 1'b1;
      end
      5'b01_011: begin
        if (rd == 5'd2) begin  // ADDI16SP
          inst_next = `ADDI; dr_next = 5'd2; sr1_next = 5'd2;
          imm_next  = {{22{c[12]}}, c[12], c[4:3], c[5], c[2], c[6], 4'b0000};
        end else begin         // LUI
          inst_next = `LUI; dr_next = rd;
          imm_next  = {{14{c[12]}}, c[12], c[6:2], 12'h000};
        end
        legal = (rd != 5'd0) && ({c[12], c[6:2]} != 6'd0);
      end
      5'b01_100: begin
        dr_next = rs1_p; sr1_next = rs1_p;
        case (c[11:10])
          2'b00: begin inst_next = `SRLI; imm_next = {27'd0, c[6:2]}; legal = !c[12]; end
          2'b01: begin inst_next = `SRAI; imm_next = {27'd0, c[6:2]}; legal = !c[12]; end
          2'b10: begin inst_next = `ANDI; imm_next = imm6_s; legal = 1'b1; end
          default: begin
            sr2_next = rd_p;
            case (c[6:5])
              2'b00:   inst_next = `SUB;
              2'b01:   inst_next = `XOR;
              2'b10:   inst_next = `OR;
              default: inst_next = `AND;
            endcase
            legal = !c[12];  // [12]=1 holds the RV64-only SUBW/ADDW group
          end
        endcase
      end
      5'b01_110, 5'b01_111: begin  // BEQZ / BNEZ
        inst_next = c[13] ? `BNE : `BEQ;
        sr1_next  = rs1_p; imm_next = bimm; legal = 1'b1;
      end
      // ---------------- quadrant 2 ----------------
      5'b10_000: begin
        inst_next = `SLLI; dr_next = rd; sr1_next = rd;
        imm_next  = {27'd0, c[6:2]}; legal = !c[12];
      end
      5'b10_010: begin
        inst_next = `LW; dr_next = rd; sr1_next = 5'd2;
        imm_next  = {24'd0, c[3:2], c[12], c[6:4], 2'b00};
        legal     = (rd != 5'd0);
      end
      5'b10_110: begin
        inst_next = `SW; sr1_next = 5'd2; sr2_next = rs2;
        imm_next  = {24'd0, c[8:7], c[12:9], 2'b00};
        legal     = 1'b1;
      end
      5'b10_100: begin
        if (rs2 == 5'd0) begin  // JR / JALR; rs1=0 is EBREAK or reserved
          inst_next = `JALR; dr_next = {4'd0, c[12]}; sr1_next = rd;
          legal     = (rd != 5'd0);
        end else begin          // MV copies from x0 + rs2, ADD accumulates
          inst_next = `ADD; dr_next = rd; sr1_next = c[12] ? rd : 5'd0; sr2_next = rs2;
          legal     = 1'b1;
        end
      end
      default: legal = 1'b0;  // FP loads/stores, reserved, and 32-bit encodings
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bus.com_inst_o     <= 8'd0;
      bus.com_reg_dr_o   <= 5'd0;
      bus.com_reg_sr1_o  <= 5'd0;
      bus.com_reg_sr2_o  <= 5'd0;
      bus.com_imm_data_o <= 32'd0;
      bus.com_inst_val_o <= 1'b0;
    end else begin
      bus.com_inst_o     <= legal ? inst_next : `ILLEGAL;
      bus.com_reg_dr_o   <= legal ? dr_next   : 5'd0;
      bus.com_reg_sr1_o  <= legal ? sr1_next  : 5'd0;
      bus.com_reg_sr2_o  <= legal ? sr2_next  : 5'd0;
      bus.com_imm_data_o <= legal ? imm_next  : 32'd0;
      bus.com_inst_val_o <= legal;
    end
  end

endmodule

// File: tb/tb_decode_compressed.sv
// tb_decode_compressed
//   Drives hand-assembled RV32C encodings into decode_compressed, pushes the
//   hand-derived expansion onto a scoreboard queue at drive time and pops it
//   one clock edge later to compare against the registered outputs.
module tb_decode_compressed;

  localparam logic [7:0] C_LUI = 8'd1,  C_JAL = 8'd3,  C_JALR = 8'd4, C_BEQ = 8'd5;
  localparam logic [7:0] C_BNE = 8'd6,  C_LW = 8'd13,  C_SW = 8'd18,  C_ADDI = 8'd19;
  localparam logic [7:0] C_ANDI = 8'd25, C_SLLI = 8'd26, C_SRLI = 8'd27, C_SRAI = 8'd28;
  localparam logic [7:0] C_ADD = 8'd29, C_SUB = 8'd30, C_XOR = 8'd33, C_OR = 8'd36;
  localparam logic [7:0] C_AND = 8'd37, C_ILLEGAL = 8'd63;

  typedef struct packed {
    logic [15:0] inst;
    logic [7:0]  code;
    logic [4:0]  dr, sr1, sr2;
    logic [31:0] imm;
    logic        val;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests_run = 0;
  int   tests_failed = 0;
  exp_t sb[$];

  decode_compressed_if bus();

  decode_compressed dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [15:0] inst, input logic [7:0] code,
                              input int dr, input int sr1, input int sr2,
                              input logic [31:0] imm);
    exp_t e;
    e.inst = inst; e.code = code; e.dr = 5'(dr); e.sr1 = 5'(sr1); e.sr2 = 5'(sr2);
    e.imm = imm; e.val = 1'b1;
    return e;
  endfunction

  function automatic exp_t ill(input logic [15:0] inst);
    exp_t e;
    e = mk(inst, C_ILLEGAL, 0, 0, 0, 32'd0);
    e.val = 1'b0;
    return e;
  endfunction

  // Observed outputs packed in the same order as the expectation fields.
  function automatic logic [55:0] observed();
    return {bus.com_inst_o, bus.com_reg_dr_o, bus.com_reg_sr1_o, bus.com_reg_sr2_o,
            bus.com_imm_data_o, bus.com_inst_val_o};
  endfunction

  // Apply one instruction in the low phase, record its expectation, and
  // return #1 after the edge that registers it.
  task automatic drive(input exp_t e);
    @(negedge clk);
    bus.com_inst_i = e.inst;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    bus.com_inst_i = 16'h4501;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    e = mk(16'h4501, 8'd0, 0, 0, 0, 32'd0);
    e.val = 1'b0;
    tests_run++;
    if (observed() !== {e.code, e.dr, e.sr1, e.sr2, e.imm, e.val}) begin
      tests_failed++;
      $display("FAIL reset_state got=%h want=%h", observed(), {e.code, e.dr, e.sr1, e.sr2, e.imm, e.val});
    end else $display("[TB] reset_state outputs=%h ok", observed());
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_spec_vectors();
    exp_t v[$];
    exp_t e;
    v.push_back(mk(16'h4501, C_ADDI, 10, 0, 0, 32'd0));
    v.push_back(mk(16'h952E, C_ADD, 10, 10, 11, 32'd0));
    v.push_back(mk(16'h41C8, C_LW, 10, 11, 0, 32'd4));
    v.push_back(mk(16'hBFFD, C_JAL, 0, 0, 0, 32'hFFFFFFFE));
    v.push_back(mk(16'hDC7D, C_BEQ, 0, 8, 0, 32'hFFFFFFFE));
    v.push_back(mk(16'hD8E5, C_BEQ, 0, 9, 0, 32'hFFFFFFF0));
    foreach (v[i]) begin
      drive(v[i]);
      e = sb.pop_front();
      tests_run++;
      if (observed() !== {e.code, e.dr, e.sr1, e.sr2, e.imm, e.val}) begin
        tests_failed++;
        $display("FAIL spec_vector inst=%h got=%h want=%h", e.inst, observed(), {e.code, e.dr, e.sr1, e.sr2, e.imm, e.val});
      end else $display("[TB] spec_vector inst=%h code=%0d imm=%h ok", e.inst, e.code, e.imm);
    end
  endtask

  task automatic test_quadrant0();
    exp_t v[$];
    exp_t e;
    v.push_back(mk(16'h0028, C_ADDI, 10, 2, 0, 32'd8));   // c.addi4spn a0,sp,8
    v.push_back(mk(16'hC1C8, C_SW, 0, 11, 10, 32'd4));    // c.sw a0,4(a1)
    v.push_back(ill(16'h0008));                           // addi4spn zero imm
    v.push_back(ill(16'h0000));
    v.push_back(ill(16'h2008));                           // c.fld
    foreach (v[i]) begin
      drive(v[i]);
      e = sb.pop_front();
      tests_run++;
      if (observed() !== {e.code, e.dr, e.sr1, e.sr2, e.imm, e.val}) begin
        tests_failed++;
        $display("FAIL quadrant0 inst=%h got=%h want=%h", e.inst, observed(), {e.code, e.dr, e.sr1, e.sr2, e.imm, e.val});
      end else $display("[TB] quadrant0 inst=%h code=%0d ok", e.inst, e.code);
    end
  endtask

  task automatic test_quadrant1();
    exp_t v[$];
    exp_t e;
    v.push_back(mk(16'h157D, C_ADDI, 10, 10, 0, 32'hFFFFFFFF)); // c.addi a0,-1
    v.push_back(mk(16'h2011, C_JAL, 1, 0, 0, 32'd4));           // c.jal +4
    v.push_back(mk(16'h717D, C_ADDI, 2, 2, 0, 32'hFFFFFFF0));   // c.addi16sp -16
    v.push_back(mk(16'h6785, C_LUI, 15, 0, 0, 32'h00001000));   // c.lui a5,1
    v.push_back(mk(16'h77FD, C_LUI, 15, 0, 0, 32'hFFFFF000));   // c.lui a5,0xfffff
    v.push_back(ill(16'h6005));                                 // lui rd=0
    v.push_back(ill(16'h6781));                                 // lui imm=0
    v.push_back(ill(16'h6101));                                 // addi16sp imm=0
    v.push_back(mk(16'h810D, C_SRLI, 10, 10, 0, 32'd3));
    v.push_back(mk(16'h850D, C_SRAI, 10, 10, 0, 32'd3));
    v.push_back(ill(16'h910D));                                 // shamt[5]=1
    v.push_back(mk(16'h9979, C_ANDI, 10, 10, 0, 32'hFFFFFFFE));
    v.push_back(mk(16'h8C05, C_SUB, 8, 8, 9, 32'd0));
    v.push_back(mk(16'h8C25, C_XOR, 8, 8, 9, 32'd0));
    v.push_back(mk(16'h8C45, C_OR, 8, 8, 9, 32'd0));
    v.push_back(mk(16'h8C65, C_AND, 8, 8, 9, 32'd0));
    v.push_back(ill(16'h9C05));                                 // c.subw
    v.push_back(mk(16'hE481, C_BNE, 0, 9, 0, 32'd8));           // c.bnez s1,+8
    foreach (v[i]) begin
      drive(v[i]);
      e = sb.pop_front();
      tests_run++;
      if (observed() !== {e.code, e.dr, e.sr1, e.sr2, e.imm, e.val}) begin
        tests_failed++;
        $display("FAIL quadrant1 inst=%h got=%h want=%h", e.inst, observed(), {e.code, e.dr, e.sr1, e.sr2, e.imm, e.val});
      end else $display("[TB] quadrant1 inst=%h code=%0d ok", e.inst, e.code);
    end
  endtask

  task automatic test_quadrant2();
    exp_t v[$];
    exp_t e;
    v.push_back(mk(16'h050A, C_SLLI, 10, 10, 0, 32'd2));
    v.push_back(ill(16'h150A));                          // shamt[5]=1
    v.push_back(mk(16'h4532, C_LW, 10, 2, 0, 32'd12));   // c.lwsp a0,12(sp)
    v.push_back(ill(16'h4032));                          // lwsp rd=0
    v.push_back(mk(16'hC42A, C_SW, 0, 2, 10, 32'd8));    // c.swsp a0,8(sp)
    v.push_back(mk(16'h8082, C_JALR, 0, 1, 0, 32'd0));   // c.jr ra
    v.push_back(mk(16'h852E, C_ADD, 10, 0, 11, 32'd0));  // c.mv a0,a1
    v.push_back(mk(16'h9502, C_JALR, 1, 10, 0, 32'd0));  // c.jalr a0
    v.push_back(ill(16'h8002));                          // jr x0
    v.push_back(ill(16'h9002));                          // c.ebreak
    v.push_back(ill(16'h2002));                          // c.fldsp
    foreach (v[i]) begin
      drive(v[i]);
      e = sb.pop_front();
      tests_run++;
      if (observed() !== {e.code, e.dr, e.sr1, e.sr2, e.imm, e.val}) begin
        tests_failed++;
        $display("FAIL quadrant2 inst=%h got=%h want=%h", e.inst, observed(), {e.code, e.dr, e.sr1, e.sr2, e.imm, e.val});
      end else $display("[TB] quadrant2 inst=%h code=%0d ok", e.inst, e.code);
    end
  endtask

  task automatic test_back_to_back();
    exp_t v[$];
    exp_t e;
    v.push_back(mk(16'h4501, C_ADDI, 10, 0, 0, 32'd0));
    v.push_back(ill(16'h0013));                          // 32-bit encoding
    v.push_back(mk(16'h952E, C_ADD, 10, 10, 11, 32'd0));
    v.push_back(ill(16'hFFFF));
    v.push_back(mk(16'hD8E5, C_BEQ, 0, 9, 0, 32'hFFFFFFF0));
    v.push_back(ill(16'h0003));
    foreach (v[i]) begin
      drive(v[i]);
      e = sb.pop_front();
      tests_run++;
      if (observed() !== {e.code, e.dr, e.sr1, e.sr2, e.imm, e.val}) begin
        tests_failed++;
        $display("FAIL back_to_back inst=%h got=%h want=%h", e.inst, observed(), {e.code, e.dr, e.sr1, e.sr2, e.imm, e.val});
      end else $display("[TB] back_to_back inst=%h code=%0d ok", e.inst, e.code);
    end
  endtask

  task automatic test_async_reset();
    exp_t e;
    exp_t z;
    z = ill(16'h952E);
    z.code = 8'd0;
    drive(mk(16'h952E, C_ADD, 10, 10, 11, 32'd0));
    e = sb.pop_front();
    tests_run++;
    if (observed() !== {e.code, e.dr, e.sr1, e.sr2, e.imm, e.val}) begin
      tests_failed++;
      $display("FAIL async_pre inst=%h got=%h want=%h", e.inst, observed(), {e.code, e.dr, e.sr1, e.sr2, e.imm, e.val});
    end else $display("[TB] async_pre inst=%h ok", e.inst);
    // Assert reset in the high phase, well clear of any edge.
    #2 rst = 1'b1;
    sb.push_back(z);
    #1;
    e = sb.pop_front();
    tests_run++;
    if (observed() !== {e.code, e.dr, e.sr1, e.sr2, e.imm, e.val}) begin
      tests_failed++;
      $display("FAIL async_immediate got=%h want=%h", observed(), {e.code, e.dr, e.sr1, e.sr2, e.imm, e.val});
    end else $display("[TB] async_immediate outputs=%h ok", observed());
    sb.push_back(z);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    tests_run++;
    if (observed() !== {e.code, e.dr, e.sr1, e.sr2, e.imm, e.val}) begin
      tests_failed++;
      $display("FAIL async_held got=%h want=%h", observed(), {e.code, e.dr, e.sr1, e.sr2, e.imm, e.val});
    end else $display("[TB] async_held outputs=%h ok", observed());
    @(negedge clk);
    rst = 1'b0;
    sb.push_back(mk(16'h952E, C_ADD, 10, 10, 11, 32'd0));
    @(posedge clk);
    #1;
    e = sb.pop_front();
    tests_run++;
    if (observed() !== {e.code, e.dr, e.sr1, e.sr2, e.imm, e.val}) begin
      tests_failed++;
      $display("FAIL async_release inst=%h got=%h want=%h", e.inst, observed(), {e.code, e.dr, e.sr1, e.sr2, e.imm, e.val});
    end else $display("[TB] async_release inst=%h ok", e.inst);
  endtask

  initial begin
    test_reset();
    test_spec_vectors();
    test_quadrant0();
    test_quadrant1();
    test_quadrant2();
    test_back_to_back();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout after %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
